// File: rtl/lvdc_timing_pkg.sv
// Shared constants and slot encoding for the LVDA/LVDC master timing chain.
package lvdc_timing_pkg;
    typedef enum logic [1:0] {
        SLOT_W = 2'd0,
        SLOT_X = 2'd1,
        SLOT_Y = 2'd2,
        SLOT_Z = 2'd3
    } slot_e;

    localparam int DEF_SLOT_TICKS  = 4;
    localparam int DEF_PULSE_TICKS = 3;
    localparam int DEF_NUM_BT      = 14;
    localparam int PH_W            = 2;
endpackage

// File: rtl/timing_slot_counter.sv
// Tick/slot counter: walks W->X->Y->Z, SLOT_TICKS clocks per slot, wrap marks the bit-time end.
module timing_slot_counter
    import lvdc_timing_pkg::*;
#(
    parameter int SLOT_TICKS = DEF_SLOT_TICKS,
    parameter int TICK_W     = $clog2(SLOT_TICKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output slot_e             slot,
    output logic [TICK_W-1:0] tick,
    output logic              wrap
);
    logic tick_last;

    assign tick_last = (tick == TICK_W'(SLOT_TICKS - 1));
    assign wrap      = en && tick_last && (slot == SLOT_Z);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= '0;
            slot <= SLOT_W;
        end else if (en) begin
            if (tick_last) begin
                tick <= '0;
                slot <= slot_e'(2'(slot) + 2'd1);
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end
endmodule

// File: rtl/timing_gen.sv
// Master timing generator: four non-overlapping DA phases per bit time, BT/PH counters, run/halt/step.
module timing_gen
    import lvdc_timing_pkg::*;
#(
    parameter int SLOT_TICKS  = DEF_SLOT_TICKS,
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int NUM_BT      = DEF_NUM_BT,
    parameter int BT_W        = 4
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            RUN,
    input  logic            STEP,
    output logic            WDA,
    output logic            XDA,
    output logic            YDA,
    output logic            ZDA,
    output logic [BT_W-1:0] BT,
    output logic [PH_W-1:0] PH,
    output logic            BT_END,
    output logic            PH_END,
    output logic            HALTED
);
    localparam int TICK_W = $clog2(SLOT_TICKS);

    if (PULSE_TICKS < 1 || PULSE_TICKS >= SLOT_TICKS) begin : g_bad_pulse
        $error("timing_gen: PULSE_TICKS must be in [1, SLOT_TICKS-1]");
    end
    if ((1 << BT_W) < NUM_BT) begin : g_bad_bt_w
        $error("timing_gen: BT_W too narrow for NUM_BT");
    end

    slot_e             slot;
    logic [TICK_W-1:0] tick;
    logic              bt_wrap;
    logic              running;
    logic              step_pending;
    logic              stop;
    logic [3:0]        da;

    timing_slot_counter #(
        .SLOT_TICKS(SLOT_TICKS),
        .TICK_W    (TICK_W)
    ) u_slot (
        .clk  (SIM_CLK),
        .rst_n(SIM_RST),
        .en   (running),
        .slot (slot),
        .tick (tick),
        .wrap (bt_wrap)
    );

    // A stepped bit time halts exactly like a free run with RUN low.
    assign stop = !RUN || (step_pending && !RUN);

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            running      <= 1'b0;
            step_pending <= 1'b0;
            BT           <= '0;
            PH           <= '0;
            da           <= '0;
            BT_END       <= 1'b0;
            PH_END       <= 1'b0;
        end else begin
            if (!running) begin
                if (RUN || STEP) begin
                    running      <= 1'b1;
                    step_pending <= STEP && !RUN;
                end
            end else begin
                if (RUN) step_pending <= 1'b0;
                if (bt_wrap) begin
                    if (BT == BT_W'(NUM_BT - 1)) begin
                        BT <= '0;
                        PH <= PH + PH_W'(1);
                    end else begin
                        BT <= BT + BT_W'(1);
                    end
                    if (stop) begin
                        running      <= 1'b0;
                        step_pending <= 1'b0;
                    end
                end
            end
            da     <= (running && tick < TICK_W'(PULSE_TICKS)) ? (4'b0001 << slot) : 4'b0000;
            BT_END <= bt_wrap;
            PH_END <= bt_wrap && (BT == BT_W'(NUM_BT - 1));
        end
    end

    assign {ZDA, YDA, XDA, WDA} = da;
    assign HALTED = !running;
endmodule

// File: tb/tb_timing_gen.sv
module tb_timing_gen;
    localparam int ST  = 4;
    localparam int PT  = 3;
    localparam int NBT = 14;
    localparam int BTL = 4 * ST;

    typedef struct packed {
        logic [3:0] da;
        logic       bt_end;
        logic       ph_end;
        logic       halted;
        logic [3:0] bt;
        logic [1:0] ph;
    } obs_t;

    logic       SIM_CLK = 1'b0;
    logic       SIM_RST = 1'b0;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic       WDA, XDA, YDA, ZDA, BT_END, PH_END, HALTED;
    logic [3:0] BT;
    logic [1:0] PH;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    timing_gen dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .RUN(RUN), .STEP(STEP),
        .WDA(WDA), .XDA(XDA), .YDA(YDA), .ZDA(ZDA),
        .BT(BT), .PH(PH), .BT_END(BT_END), .PH_END(PH_END), .HALTED(HALTED)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    initial begin
        bit m_run;
        int pos, bt, ph;
        obs_t e;
        m_run = 0; pos = 0; bt = 0; ph = 0;
        forever begin
            @(posedge SIM_CLK);
            e = '0;
            if (!SIM_RST) begin
                m_run = 0; pos = 0; bt = 0; ph = 0;
            end else if (m_run) begin
                if ((pos % ST) < PT) e.da = 4'(1 << (pos / ST));
                if (pos == BTL - 1) begin
                    e.bt_end = 1'b1;
                    e.ph_end = (bt == NBT - 1);
                    bt = bt + 1;
                    if (bt == NBT) begin bt = 0; ph = (ph + 1) % 4; end
                    if (!RUN) m_run = 0;
                end
                pos = (pos + 1) % BTL;
            end else if (RUN || STEP) begin
                m_run = 1;
            end
            e.bt = 4'(bt);
            e.ph = 2'(ph);
            e.halted = !m_run;
            exp_q.push_back(e);
        end
    end

    initial begin
        obs_t a, e;
        forever begin
            @(posedge SIM_CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{da: {ZDA, YDA, XDA, WDA}, bt_end: BT_END, ph_end: PH_END,
                      halted: HALTED, bt: BT, ph: PH};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t got da=%b bte=%b phe=%b hlt=%b bt=%0d ph=%0d expected da=%b bte=%b phe=%b hlt=%b bt=%0d ph=%0d",
                             $time, a.da, a.bt_end, a.ph_end, a.halted, a.bt, a.ph,
                             e.da, e.bt_end, e.ph_end, e.halted, e.bt, e.ph);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge SIM_CLK);
    endtask

    initial begin
        int waited;
        @(negedge SIM_CLK);
        cyc(2);
        tests++;
        if ({ZDA, YDA, XDA, WDA} !== 4'b0000 || BT_END !== 1'b0 || PH_END !== 1'b0 ||
            HALTED !== 1'b1 || BT !== 4'd0 || PH !== 2'd0) begin
            fails++;
            $display("FAIL reset state t=%0t da=%b bte=%b phe=%b hlt=%b bt=%0d ph=%0d",
                     $time, {ZDA, YDA, XDA, WDA}, BT_END, PH_END, HALTED, BT, PH);
        end
        SIM_RST = 1'b1; RUN = 1'b1;
        cyc(1 + 4 * BTL * NBT + 40);
        SIM_RST = 1'b0; cyc(1); SIM_RST = 1'b1;
        cyc(1 + 3 * BTL + 5);
        RUN = 1'b0;
        waited = 0;
        while (HALTED !== 1'b1 && waited < 25) begin
            cyc(1);
            waited++;
        end
        tests++;
        if (HALTED !== 1'b1 || BT !== 4'd4 || {ZDA, YDA, XDA, WDA} !== 4'b0000) begin
            fails++;
            $display("FAIL halt wait expired t=%0t waited=%0d hlt=%b bt=%0d da=%b",
                     $time, waited, HALTED, BT, {ZDA, YDA, XDA, WDA});
        end
        cyc((30 - waited) > 0 ? (30 - waited) : 1);
        STEP = 1'b1; cyc(1); STEP = 1'b0;
        cyc(6);
        STEP = 1'b1; cyc(1); STEP = 1'b0;
        cyc(25);
        STEP = 1'b1; cyc(1); STEP = 1'b0;
        cyc(5); RUN = 1'b1; cyc(40);
        SIM_RST = 1'b0; cyc(1); SIM_RST = 1'b1; RUN = 1'b1;
        cyc(1 + 7 * BTL + 9);
        SIM_RST = 1'b0; cyc(1); SIM_RST = 1'b1; RUN = 1'b0;
        cyc(8);
        RUN = 1'b1; STEP = 1'b1; cyc(1); STEP = 1'b0;
        cyc(3 * BTL);
        for (int i = 0; i < 3000; i++) begin
            SIM_RST = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) RUN = ~RUN;
            STEP = ($urandom_range(0, 14) == 0);
            cyc(1);
        end
        RUN = 1'b0; STEP = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Master timing generator for the LVDA/LVDC timing chain.
- Divides SIM_CLK into four non-overlapping, ordered clock phases WDA, XDA, YDA, ZDA (one W/X/Y/Z cycle per bit time).
- Maintains the bit-time and phase counters.
- Feeds timing_1 directly: its four DA outputs are the sole inputs that timing_1 fans out to the W/X/Y/Z buffer nets. Also provides run/halt/single-step control for the timing chain.

Parameters:
- SLOT_TICKS, 4: SIM_CLK cycles per W/X/Y/Z slot.
- PULSE_TICKS, 3: cycles a DA line is high at the start of its slot. Must satisfy 1 <= PULSE_TICKS < SLOT_TICKS, which guarantees a low gap between phases. Violation is an elaboration error.
- NUM_BT, 14: bit times per phase.
- BT_W, 4: width of the bit-time count; must satisfy 2^BT_W >= NUM_BT.

Ports:
- SIM_CLK  in  1  sole clock; all state updates on the rising edge.
- SIM_RST  in  1  reset; synchronous, active-low.
- RUN  in  1  level; 1 = free-run, 0 = halt at the next bit-time boundary.
- STEP  in  1  single-cycle pulse; while halted, runs exactly one bit time.
- WDA  out  1  W phase drive.
- XDA  out  1  X phase drive.
- YDA  out  1  Y phase drive.
- ZDA  out  1  Z phase drive.
- BT  out  BT_W  current bit time, 0..NUM_BT-1.
- PH  out  2  current phase, 0..3.
- BT_END  out  1  one-cycle pulse in the last cycle of a bit time (slot Z, final tick).
- PH_END  out  1  BT_END qualified with BT==NUM_BT-1.
- HALTED  out  1  generator is idle at a bit-time boundary.

Behaviour:
- Registered state:
  - tick: 0..SLOT_TICKS-1
  - slot: W, X, Y, Z
  - BT, PH
  - running flag
  - step_pending flag
- Reset (SIM_RST=0 at an edge): tick=0, slot=W, BT=0, PH=0, running=0, step_pending=0. Outputs: WDA/XDA/YDA/ZDA=0, BT_END=0, PH_END=0, HALTED=1. Reset mid-bit-time aborts immediately; no partial phase completes.
- Start:
  - Halted and (RUN=1 or STEP=1) sampled at edge k: running=1 after edge k.
  - WDA is high after edge k+1 (one cycle latency from request to first phase).
  - A STEP request sets step_pending.
- While running, per edge:
  - tick increments.
  - At tick=SLOT_TICKS-1, tick wraps to 0 and slot advances W->X->Y->Z->W.
  - On Z->W, BT increments. At BT=NUM_BT-1, BT wraps to 0 and PH increments mod 4.
- DA outputs are registered decodes, glitch-free: xDA=1 iff running, slot==x and tick<PULSE_TICKS, delayed one cycle from the counter state.
  - At most one DA is high in any cycle.
  - Each DA is high exactly PULSE_TICKS consecutive cycles per bit time.
  - Bit time length is 4*SLOT_TICKS cycles (16 at defaults).
- BT_END and PH_END are registered with the same one-cycle alignment as the DA lines.
- Halt, evaluated only at a bit-time boundary (the edge where slot wraps Z->W):
  - If RUN=0, or step_pending=1 and RUN=0: running=0, step_pending=0, HALTED=1. BT/PH hold the already-incremented values.
  - Otherwise continue.
  - RUN dropping mid-bit-time never truncates a bit time.
- STEP while running: ignored, not queued.
- RUN=1 and STEP=1 simultaneously: RUN wins; free-run, step_pending=0.
- RUN reasserted during a stepped bit time: step_pending cleared; free-run continues.
- HALTED=0 from the edge running is set until the boundary edge that clears it.

Decomposition:
- Package lvdc_timing_pkg holds:
  - slot enum (SLOT_W, SLOT_X, SLOT_Y, SLOT_Z)
  - default SLOT_TICKS, PULSE_TICKS, NUM_BT
  - the PH width constant
- One sub-module, timing_slot_counter: the tick/slot counter with enable, emitting slot, tick and a wrap pulse.
- The top level, timing_gen, holds:
  - BT/PH counters
  - run/step control
  - registered DA decode

Test Plan:
1. Reset, RUN=1 at cycle 0 -> WDA high cycles 2-4, XDA 6-8, YDA 10-12, ZDA 14-16. BT_END at cycle 17. BT=1 thereafter. Never two DAs high together.
2. Free-run 224 cycles -> BT walks 0..13 and wraps to 0. PH 0->1. PH_END single pulse. A further 672 cycles -> PH wraps 3->0.
3. RUN dropped at cycle 5 of bit time 3 -> bit time completes with full ZDA pulse. HALTED=1 with BT=4. All DAs low while halted.
4. Halted, single STEP pulse -> exactly one W/X/Y/Z sequence (3 cycles each). BT 4->5. HALTED reasserts. A second STEP mid-sequence has no extra effect.
5. SIM_RST=0 asserted during YDA of bit time 7 -> next cycle all DAs 0, BT=0, PH=0, HALTED=1. No spurious ZDA.
6. RUN and STEP asserted in the same cycle while halted -> free-run; no halt after the first bit time.
